// File: rtl/crc5_frame_tx.sv
// crc5_frame_tx: serializes a payload word MSB-first
// and appends its CRC-5 (x^5+x^2+1, init 0).
module crc5_frame_tx #(
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              bit_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = $clog2(DATA_W + 6);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] sr;
  logic [4:0]        crc;
  logic [CW-1:0]     cnt;
  logic              done;
  logic              data_end;
  logic              fb;

  assign data_end   = (cnt == CW'(DATA_W - 1));
  assign fb         = crc[4] ^ sr[DATA_W-1];
  assign busy       = (state != IDLE);
  assign frame_done = done;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // next state and handshake/serial outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    bit_last  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = rst;
        if (in_valid) state_nx = DATA;
      end
      DATA: begin
        bit_valid = 1'b1;
        bit_out   = sr[DATA_W-1];
        if (out_ready && data_end)
          state_nx = CRC;
      end
      CRC: begin
        bit_valid = 1'b1;
        bit_out   = crc[4];
        bit_last  = (cnt == CW'(4));
        if (out_ready && bit_last)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // shift register, running CRC, bit counter, done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr   <= '0;
      crc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr  <= in_data;
            crc <= '0;
            cnt <= '0;
          end
        end
        DATA: begin
          if (out_ready) begin
            sr  <= sr << 1;
            crc <= {crc[3:0], 1'b0}
                   ^ (fb ? 5'h05 : 5'h00);
            if (data_end) cnt <= '0;
            else          cnt <= cnt + CW'(1);
          end
        end
        CRC: begin
          if (out_ready) begin
            crc <= {crc[3:0], 1'b0};
            if (cnt == CW'(4)) begin
              cnt  <= '0;
              done <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/crc5_frame_tx.md
Name: crc5_frame_tx

Overview:
Transmit-side framer that sits directly upstream of the CRC-5 (poly 0x25) bit-serial stage. Accepts a parallel payload word over a valid/ready handshake and serializes it MSB-first. Computes CRC-5 (x^5+x^2+1, init 0, MSB-first) on the fly and appends the 5 CRC bits MSB-first. The serial output (bit_valid/bit_out) connects directly to a downstream CRC-5 stage's en/din. Feeding a whole frame into such a stage (starting from 0) leaves a remainder of 0.

Parameters:
DATA_W, 11, payload width in bits (>= 1); frame length = DATA_W + 5 bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  active-low asynchronous reset
in_valid  input  1  payload word available
in_ready  output  1  framer can accept a word (high only in IDLE)
in_data  input  DATA_W  payload word; bit DATA_W-1 is transmitted first
out_ready  input  1  downstream accepts the current bit this cycle
bit_valid  output  1  bit_out holds a valid frame bit
bit_out  output  1  current serial bit
bit_last  output  1  current bit is the final CRC bit (CRC bit 0)
busy  output  1  frame in progress (state != IDLE)
frame_done  output  1  one-cycle pulse the cycle after the last bit is accepted

Behaviour:
- Reset (rst low, async): state IDLE, shift register and CRC cleared to 0, bit counter 0. Outputs: in_ready=0 while rst is asserted, then 1 in IDLE. bit_valid=0, bit_out=0, bit_last=0, busy=0, frame_done=0.
- States: IDLE, DATA, CRC. A bit is "accepted" on any edge where bit_valid && out_ready.
- IDLE: in_ready=1, bit_valid=0. On in_valid && in_ready, latch in_data and clear CRC to 0. Next cycle enter DATA with bit_valid=1 and bit_out=in_data[DATA_W-1]. Latency from accept to first valid bit: 1 cycle.
- DATA: bit_out = MSB of shift register. On accept:
  - Shift left.
  - CRC update: fb = crc[4]^bit_out; crc <= {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b0).
  - Counter increments.
  - After DATA_W accepts, go to CRC with bit_valid still 1.
- CRC: bit_out = crc[4] of the final CRC. On accept, shift the CRC left by 1 (no further polynomial update). bit_last=1 on the 5th CRC bit.
  - On accepting the 5th CRC bit: next cycle state=IDLE, bit_valid=0, frame_done=1 for exactly one cycle, in_ready=1.
  - Minimum gap between frames: the 1 IDLE cycle.
- Backpressure: while out_ready=0, bit_out, bit_last, state, CRC and counter all hold. bit_valid stays 1 and is never dropped mid-frame.
- in_valid is ignored outside IDLE. in_data is sampled only at accept, so it may change afterwards.
- Async reset mid-frame aborts immediately to reset values with no frame_done.
- Throughput: with out_ready held at 1, one bit per cycle and DATA_W+5 bits in DATA_W+5 consecutive cycles.
- DATA_W=1 is legal: DATA lasts one accepted bit.

Test Plan:
1. Reset, DATA_W=11, in_data=11'h400, out_ready=1:
   - Bits are 1, 0×10, then CRC 1,1,1,1,1 (CRC=5'h1F).
   - bit_last on bit 16. frame_done 1 cycle later.
   - bit_valid high for exactly 16 cycles.
2. in_data=11'h001 → bits 0×10, 1, then CRC 0,0,1,0,1 (5'h05).
   - in_data=11'h000 → 16 zero bits (CRC 5'h00).
3. Drive bit_valid/bit_out into a reference crc5 MSB-first stage reset to 0 → after 16 accepts its CRC reads 5'h00, for 100 random payloads.
4. Backpressure: random out_ready (about 50%) with in_data=11'h400 → same 16-bit sequence as scenario 1. bit_out/bit_last are stable while out_ready=0, and bit_valid never deasserts mid-frame.
5. in_valid held high continuously → in_ready high only in IDLE. Words are accepted one IDLE cycle after each frame_done, and in_data changes during a frame do not corrupt it.
6. Assert rst after 7 data bits → all outputs are at reset values immediately and no frame_done is produced. After release, a new frame with 11'h001 transmits correctly.
